// File: rtl/soma_mmio_pkg.sv
// soma_mmio_pkg: shared constants and read-context types for the SOMA MMIO CSR responder
package soma_mmio_pkg;
    localparam logic [15:0] DFH_OFF      = 16'h0000;
    localparam logic [15:0] AFU_ID_L_OFF = 16'h0008;
    localparam logic [15:0] AFU_ID_H_OFF = 16'h0010;
    localparam logic [15:0] RSVD_OFF     = 16'h0018;
    localparam logic [63:0] DFH_VAL      = {4'h1, 19'd0, 1'b1, 40'd0};
    localparam int CTX_TID_W = 16;
    localparam int CTX_IDX_W = 16;

    typedef enum logic [2:0] {REG_DFH, REG_ID_L, REG_ID_H, REG_ZERO, REG_APP} t_region;

    typedef struct packed {
        logic [CTX_TID_W-1:0] tid;
        t_region              region;
        logic [CTX_IDX_W-1:0] idx;
        logic                 len;
        logic                 hi;
    } t_rd_ctx;

    function automatic logic [63:0] size_data(input logic [63:0] d, input logic len, input logic hi);
        return len ? d : {32'd0, hi ? d[63:32] : d[31:0]};
    endfunction
endpackage

// File: rtl/soma_mmio_if.sv
// soma_mmio_if: host MMIO request and tagged read-response channel
interface soma_mmio_if #(
    parameter int MMIO_ADDR_W = 16,
    parameter int TID_W       = 9
);
    logic                   mmio_req_valid;
    logic                   mmio_req_ready;
    logic                   mmio_req_write;
    logic [MMIO_ADDR_W-1:0] mmio_req_addr;
    logic                   mmio_req_len;
    logic [TID_W-1:0]       mmio_req_tid;
    logic [63:0]            mmio_req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [TID_W-1:0]       rsp_tid;
    logic [63:0]            rsp_data;

    modport master (
        output mmio_req_valid, mmio_req_write, mmio_req_addr, mmio_req_len, mmio_req_tid, mmio_req_data, rsp_ready,
        input  mmio_req_ready, rsp_valid, rsp_tid, rsp_data
    );
    modport slave (
        input  mmio_req_valid, mmio_req_write, mmio_req_addr, mmio_req_len, mmio_req_tid, mmio_req_data, rsp_ready,
        output mmio_req_ready, rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/soma_rsp_fifo.sv
// soma_rsp_fifo: first-word-fall-through response FIFO exposing its occupancy
module soma_rsp_fifo #(
    parameter int W     = 73,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_pop;
    logic          w_push;

    assign w_pop   = i_pop && r_cnt != '0;
    assign w_push  = i_push && (r_cnt != CW'(DEPTH) || w_pop);
    assign o_valid = r_cnt != '0;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/soma_mmio_csr_responder.sv
// soma_mmio_csr_responder: decodes host MMIO into CSR write strobes and tagged read responses
module soma_mmio_csr_responder
    import soma_mmio_pkg::*;
#(
    parameter int          NUM_APP_CSRS   = 32,
    parameter int          MMIO_ADDR_W    = 16,
    parameter int          TID_W          = 9,
    parameter logic [15:0] APP_CSR_BASE   = 16'h0020,
    parameter int          RSP_FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        SoftReset_n,
    soma_mmio_if.slave                  mmio,
    input  logic [127:0]                afu_id,
    input  logic [64*NUM_APP_CSRS-1:0]  app_rd_data,
    output logic [NUM_APP_CSRS-1:0]     app_wr_en,
    output logic [63:0]                 app_wr_data,
    output logic [15:0]                 err_cnt
);
    localparam int BW    = MMIO_ADDR_W + 2;
    localparam int IDX_W = $clog2(NUM_APP_CSRS);
    localparam int CW    = $clog2(RSP_FIFO_DEPTH) + 1;

    logic [BW-1:0]      w_byte;
    logic [BW-1:0]      w_qw;
    logic [BW-1:0]      w_off;
    logic [IDX_W-1:0]   w_idx;
    logic               w_acc;
    logic               w_fixed;
    logic               w_app_ok;
    logic               w_wr_ok;
    logic               w_wr_go;
    logic               w_rd_go;
    logic               w_err;
    t_region            w_region;
    logic [63:0]        w_raw;
    logic [63:0]        w_app [NUM_APP_CSRS];
    logic [CW-1:0]      w_count;
    logic [TID_W+63:0]  w_rsp;
    logic               r_s1_v;
    t_rd_ctx            r_s1;

    assign w_byte   = {mmio.mmio_req_addr, 2'b00};
    assign w_qw     = {w_byte[BW-1:3], 3'b000};
    assign w_off    = w_byte - BW'(APP_CSR_BASE);
    assign w_idx    = w_off[IDX_W+2:3];
    assign w_fixed  = w_byte < BW'(RSVD_OFF + 16'd8);
    assign w_app_ok = !w_fixed && w_byte >= BW'(APP_CSR_BASE) && w_off < BW'(8 * NUM_APP_CSRS);
    assign w_wr_ok  = w_app_ok && mmio.mmio_req_len && !mmio.mmio_req_addr[0];
    // Reads still in S1 count against FIFO space so a push can never overflow
    assign mmio.mmio_req_ready = SoftReset_n && (32'(w_count) + 32'(r_s1_v) < 32'(RSP_FIFO_DEPTH));
    assign w_acc    = mmio.mmio_req_valid && mmio.mmio_req_ready;
    assign w_wr_go  = w_acc && mmio.mmio_req_write && w_wr_ok;
    assign w_rd_go  = w_acc && !mmio.mmio_req_write;
    assign w_err    = w_acc && (mmio.mmio_req_write ? !w_wr_ok : !(w_fixed || w_app_ok));
    assign w_region = w_qw == BW'(DFH_OFF)      ? REG_DFH  :
                      w_qw == BW'(AFU_ID_L_OFF) ? REG_ID_L :
                      w_qw == BW'(AFU_ID_H_OFF) ? REG_ID_H :
                      w_app_ok                  ? REG_APP  : REG_ZERO;

    for (genvar i = 0; i < NUM_APP_CSRS; i++) begin : g_app
        assign w_app[i] = app_rd_data[64*i +: 64];
    end

    assign w_raw = r_s1.region == REG_DFH  ? DFH_VAL        :
                   r_s1.region == REG_ID_L ? afu_id[63:0]   :
                   r_s1.region == REG_ID_H ? afu_id[127:64] :
                   r_s1.region == REG_APP  ? w_app[r_s1.idx[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_s1_v      <= 1'b0;
            r_s1        <= '0;
            app_wr_en   <= '0;
            app_wr_data <= '0;
            err_cnt     <= '0;
        end else begin
            r_s1_v    <= w_rd_go;
            app_wr_en <= w_wr_go ? NUM_APP_CSRS'(1) << w_idx : '0;
            if (w_rd_go) r_s1 <= '{tid: CTX_TID_W'(mmio.mmio_req_tid), region: w_region, idx: CTX_IDX_W'(w_idx), len: mmio.mmio_req_len, hi: mmio.mmio_req_addr[0]};
            if (w_wr_go) app_wr_data <= mmio.mmio_req_data;
            if (w_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    soma_rsp_fifo #(.W(TID_W + 64), .DEPTH(RSP_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (SoftReset_n),
        .i_push  (r_s1_v),
        .i_data  ({TID_W'(r_s1.tid), size_data(w_raw, r_s1.len, r_s1.hi)}),
        .i_pop   (mmio.rsp_valid && mmio.rsp_ready),
        .o_valid (mmio.rsp_valid),
        .o_data  (w_rsp),
        .o_count (w_count)
    );

    assign mmio.rsp_tid  = w_rsp[TID_W+63:64];
    assign mmio.rsp_data = w_rsp[63:0];
endmodule

// File: tb/tb_soma_mmio_csr_responder.sv
// tb_soma_mmio_csr_responder: scoreboard bench for the SOMA MMIO CSR responder
module tb_soma_mmio_csr_responder;
    localparam int N = 32;
    localparam logic [63:0] DFH = {4'h1, 19'd0, 1'b1, 40'd0};

    logic             clk = 1'b0;
    logic             SoftReset_n = 1'b0;
    logic [127:0]     afu_id;
    logic [64*N-1:0]  app_rd_data;
    logic [N-1:0]     app_wr_en;
    logic [63:0]      app_wr_data;
    logic [15:0]      err_cnt;
    logic [72:0]      q [$];
    int               n_checks = 0;
    int               n_fail = 0;

    soma_mmio_if #(.MMIO_ADDR_W(16), .TID_W(9)) bus ();

    soma_mmio_csr_responder dut (
        .clk         (clk),
        .SoftReset_n (SoftReset_n),
        .mmio        (bus.slave),
        .afu_id      (afu_id),
        .app_rd_data (app_rd_data),
        .app_wr_en   (app_wr_en),
        .app_wr_data (app_wr_data),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [15:0] a, input logic l);
        logic [17:0] b;
        logic [63:0] d;
        b = {a, 2'b00};
        d = 64'd0;
        if (b[17:3] == 15'd0) d = DFH;
        else if (b[17:3] == 15'd1) d = afu_id[63:0];
        else if (b[17:3] == 15'd2) d = afu_id[127:64];
        else if (b >= 18'h20 && b < 18'h20 + 18'd256) d = app_rd_data[64*((int'(b) - 32) / 8) +: 64];
        if (!l) d = b[2] ? {32'd0, d[63:32]} : {32'd0, d[31:0]};
        return d;
    endfunction

    always @(negedge clk) begin
        if (SoftReset_n && bus.rsp_valid && bus.rsp_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got tid=%h data=%h, required no response", bus.rsp_tid, bus.rsp_data);
            end else begin
                logic [72:0] e;
                e = q.pop_front();
                if ({bus.rsp_tid, bus.rsp_data} !== e)begin
                    n_fail++;
                    $display("FAIL rsp_order: got tid=%h data=%h, required tid=%h data=%h", bus.rsp_tid, bus.rsp_data, e[72:64], e[63:0]);
                end
            end
        end
    end

    task automatic drive(input logic w, input logic [15:0] a, input logic l, input logic [8:0] t, input logic [63:0] d);
        bus.mmio_req_valid = 1'b1;
        bus.mmio_req_write = w;
        bus.mmio_req_addr  = a;
        bus.mmio_req_len   = l;
        bus.mmio_req_tid   = t;
        bus.mmio_req_data  = d;
    endtask

    task automatic idle();
        bus.mmio_req_valid = 1'b0;
        bus.mmio_req_write = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.rsp_ready = 1'b1;
        SoftReset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mmio_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b, required 0", bus.mmio_req_ready); end
        SoftReset_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.mmio_req_ready, bus.rsp_valid, bus.rsp_tid, bus.rsp_data, app_wr_en, app_wr_data, err_cnt} !== {1'b1, 1'b0, 9'd0, 64'd0, 32'd0, 64'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b rv=%b tid=%h data=%h wr_en=%h wr_data=%h err=%h, required ready=1 and all else 0",
                     bus.mmio_req_ready, bus.rsp_valid, bus.rsp_tid, bus.rsp_data, app_wr_en, app_wr_data, err_cnt);
        end
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        drive(1'b1, 16'h000C, 1'b1, 9'h0, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1;
        idle();
        n_checks++;
        if (app_wr_en !== 32'h0000_0004 || app_wr_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_fail++;
            $display("FAIL write_strobe: got en=%h data=%h, required en=00000004 data=deadbeef01234567", app_wr_en, app_wr_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (app_wr_en !== 32'd0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL write_one_cycle: got en=%h err=%h, required en=0 err=0", app_wr_en, err_cnt);
        end
    endtask

    task automatic test_read_idl();
        @(posedge clk); #1;
        drive(1'b0, 16'h0002, 1'b1, 9'h05, 64'd0);
        q.push_back({9'h05, 64'hA5A5_A5A5_A5A5_A5A5});
        n_checks++;
        if (bus.mmio_req_ready !== 1'b1) begin n_fail++; $display("FAIL read_idl_ready: got %b, required 1", bus.mmio_req_ready); end
        @(posedge clk); #1;
        idle();
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_idl_early: got rsp_valid=%b, required 0", bus.rsp_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 9'h05 || bus.rsp_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            n_fail++;
            $display("FAIL read_idl_latency: got rv=%b tid=%h data=%h, required rv=1 tid=005 data=a5a5a5a5a5a5a5a5", bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_half();
        @(posedge clk); #1;
        drive(1'b0, 16'h0009, 1'b0, 9'h06, 64'd0);
        q.push_back({9'h06, 64'h0000_0000_1111_2222});
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h0000_0000_1111_2222) begin
            n_fail++;
            $display("FAIL read_half: got rv=%b data=%h, required rv=1 data=0000000011112222", bus.rsp_valid, bus.rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [8];
        logic        lens [8];
        addrs = '{16'h0000, 16'h0001, 16'h0004, 16'h0006, 16'h0008, 16'h0008, 16'h0046, 16'h0011};
        lens  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.mmio_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, bus.mmio_req_ready); end
            drive(1'b0, addrs[i], lens[i], 9'(9'h40 + i), 64'd0);
            q.push_back({9'(9'h40 + i), model(addrs[i], lens[i])});
        end
        @(posedge clk); #1;
        idle();
        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_backpressure();
        int n_acc;
        n_acc = 0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 16'(16'h0008 + 2 * n_acc), 1'b1, 9'(9'h80 + n_acc), 64'd0);
            if (bus.mmio_req_ready === 1'b1) begin
                q.push_back({9'(9'h80 + n_acc), model(16'(16'h0008 + 2 * n_acc), 1'b1)});
                n_acc++;
            end
        end
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_acc != 4 || bus.mmio_req_ready !== 1'b0 || bus.rsp_tid !== 9'h80) begin
            n_fail++;
            $display("FAIL bp_full: got accepted=%0d ready=%b head_tid=%h, required accepted=4 ready=0 head_tid=080", n_acc, bus.mmio_req_ready, bus.rsp_tid);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0 || bus.mmio_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got pending=%0d ready=%b, required pending=0 ready=1", q.size(), bus.mmio_req_ready);
        end
        drive(1'b0, 16'h0003, 1'b0, 9'h1FF, 64'd0);
        q.push_back({9'h1FF, model(16'h0003, 1'b0)});
        @(posedge clk); #1;
        idle();
        for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL bp_resume: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_illegal();
        logic [N-1:0] seen;
        seen = '0;
        @(posedge clk); #1;
        drive(1'b1, 16'h0000, 1'b1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        seen |= app_wr_en;
        drive(1'b1, 16'h0008, 1'b0, 9'h0, 64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        seen |= app_wr_en;
        drive(1'b0, 16'h0048, 1'b1, 9'h33, 64'd0);
        q.push_back({9'h33, 64'd0});
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            idle();
            seen |= app_wr_en;
        end
        n_checks++;
        if (seen !== '0 || err_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL illegal: got strobes=%h err=%0d, required strobes=0 err=3", seen, err_cnt);
        end
        for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL illegal_rsp: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        drive(1'b0, 16'h0002, 1'b1, 9'h77, 64'd0);
        @(posedge clk); #1;
        idle();
        SoftReset_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.mmio_req_ready !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midflight_in_reset: got rv=%b ready=%b err=%0d, required 0 0 0", bus.rsp_valid, bus.mmio_req_ready, err_cnt);
        end
        @(posedge clk); #1;
        SoftReset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || bus.mmio_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_discard: got %0d cycles with rsp_valid ready=%b, required 0 cycles ready=1", bad, bus.mmio_req_ready);
        end
    endtask

    initial begin
        afu_id = {64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5};
        for (int i = 0; i < N; i++) app_rd_data[64*i +: 64] = {16'hC5A0, 16'(i), 16'h3C00, 16'(i * 3)};
        app_rd_data[63:0] = 64'h1111_2222_3333_4444;
        bus.mmio_req_addr = '0;
        bus.mmio_req_len  = 1'b0;
        bus.mmio_req_tid  = '0;
        bus.mmio_req_data = '0;
        test_reset();
        test_write();
        test_read_idl();
        test_read_half();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d pending, required 0", q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
